// File: rtl/latticesense_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : latticesense_ctrl
//  Description : Back-end for the carry-chain delay-line sensor. Registers
//                the raw thermometer sample, converts it to a bubble-tolerant
//                popcount, averages over 2^AVG_LOG2 samples and runs a
//                calibration FSM that steers the wrapper's init tap select.
//  Revision    : 1.0  initial release
// ============================================================================
module latticesense_ctrl #(
  parameter int LINE_LEN = 64,
  parameter int INIT_MAX = 32,
  parameter int INIT_DEF = 13,
  parameter int AVG_LOG2 = 4,
  parameter int CAL_LO   = 16,
  parameter int CAL_HI   = 48,
  parameter int SETTLE   = 4,
  localparam int CW      = $clog2(LINE_LEN + 1),
  localparam int SW      = $clog2(INIT_MAX)
) (
  input  logic                clkin,
  input  logic                rstnin,
  input  logic                enain,
  input  logic                calin,
  input  logic [LINE_LEN-1:0] line_in,
  output logic [SW-1:0]       init_sel,
  output logic [CW-1:0]       sample,
  output logic                sample_vld,
  output logic [CW-1:0]       avg,
  output logic                avg_vld,
  output logic                cal_busy,
  output logic                cal_done,
  output logic                cal_fail
);

  // Accumulator is wide enough for a full window of maximum counts.
  localparam int AW  = CW + AVG_LOG2;
  localparam int IW  = $clog2(INIT_MAX + 1);
  localparam int STW = $clog2(SETTLE + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_ADJUST  = 2'd3;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [LINE_LEN-1:0] line_q;
  logic                v1_q;
  logic [CW-1:0]       sample_q;
  logic                sample_vld_q;
  logic [AW-1:0]       acc_q;
  logic [AVG_LOG2-1:0] cnt_q;
  logic [CW-1:0]       avg_q;
  logic                avg_vld_q;

  logic [1:0]          state_q, state_d;
  logic [STW-1:0]      settle_q, settle_d;
  logic [IW-1:0]       iter_q, iter_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [CW-1:0]       cal_avg_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [CW-1:0]       ones;
  logic [AW-1:0]       sum;
  logic                start;
  logic                abort;
  logic                restart;
  logic                in_win;
  logic                too_fast;
  logic                at_limit;
  logic                iter_last;

  // Popcount of the captured line; bubbles simply contribute their ones.
  always_comb begin
    ones = '0;
    for (int i = 0; i < LINE_LEN; i++) begin
      ones = ones + CW'(line_q[i]);
    end
  end

  assign sum       = acc_q + AW'(sample_q);
  assign start     = (state_q == ST_IDLE) & calin & enain;
  assign abort     = (state_q != ST_IDLE) & ~enain;
  // Any cycle headed into SETTLE flushes the averager and hides samples that
  // may still reflect the previous tap setting.
  assign restart   = (state_d == ST_SETTLE);
  assign in_win    = (cal_avg_q >= CW'(CAL_LO)) && (cal_avg_q <= CW'(CAL_HI));
  assign too_fast  = (cal_avg_q > CW'(CAL_HI));
  assign at_limit  = too_fast ? (sel_q == SW'(INIT_MAX - 1)) : (sel_q == '0);
  assign iter_last = (iter_q == IW'(INIT_MAX - 1));

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // Capture stage: take the wrapper sample while enabled, else drop validity.
  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      line_q <= '0;
      v1_q   <= 1'b0;
    end else if (enain) begin
      line_q <= line_in;
      v1_q   <= 1'b1;
    end else begin
      v1_q   <= 1'b0;
    end
  end

  // Count stage: publish the popcount; suppressed while settling.
  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
    end else if (!enain) begin
      sample_vld_q <= 1'b0;
    end else begin
      sample_vld_q <= v1_q & ~restart;
      if (v1_q && !restart) begin
        sample_q <= ones;
      end
    end
  end

  // Window averager: the final sample is folded in on the same edge that
  // publishes the average and clears the window, so nothing is dropped.
  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      avg_vld_q <= 1'b0;
    end else begin
      avg_vld_q <= 1'b0;
      if (!enain || restart) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (sample_vld_q) begin
        if (cnt_q == '1) begin
          avg_q     <= sum[AVG_LOG2 +: CW];
          avg_vld_q <= 1'b1;
          acc_q     <= '0;
          cnt_q     <= '0;
        end else begin
          acc_q <= sum;
          cnt_q <= cnt_q + AVG_LOG2'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Calibration FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; losing enable while busy always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == STW'(SETTLE - 1)) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (avg_vld_q) state_d = ST_ADJUST;
      end
      ST_ADJUST: begin
        if (in_win || at_limit || iter_last) state_d = ST_IDLE;
        else                                 state_d = ST_SETTLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Output logic.
  always_comb begin
    cal_busy = (state_q != ST_IDLE);
  end

  // Calibration bookkeeping: tap stepping, iteration guard, sticky flags.
  always_comb begin
    sel_d    = sel_q;
    done_d   = done_q;
    fail_d   = fail_q;
    iter_d   = iter_q;
    settle_d = settle_q;
    if (abort) begin
      fail_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            done_d   = 1'b0;
            fail_d   = 1'b0;
            iter_d   = '0;
            settle_d = '0;
          end
        end
        ST_SETTLE: begin
          settle_d = settle_q + STW'(1);
        end
        ST_ADJUST: begin
          if (in_win) begin
            done_d = 1'b1;
          end else if (at_limit) begin
            // Tap would step out of range: stay saturated and give up.
            fail_d = 1'b1;
          end else begin
            // A high count means the line is too fast, so add initial delay.
            sel_d    = too_fast ? (sel_q + SW'(1)) : (sel_q - SW'(1));
            iter_d   = iter_q + IW'(1);
            settle_d = '0;
            if (iter_last) fail_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Calibration registers; the measured average is latched on entry to ADJUST.
  always_ff @(posedge clkin or negedge rstnin) begin
    if (!rstnin) begin
      sel_q     <= SW'(INIT_DEF);
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      iter_q    <= '0;
      settle_q  <= '0;
      cal_avg_q <= '0;
    end else begin
      sel_q    <= sel_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      iter_q   <= iter_d;
      settle_q <= settle_d;
      if (state_q == ST_MEASURE && avg_vld_q) begin
        cal_avg_q <= avg_q;
      end
    end
  end

  assign init_sel   = sel_q;
  assign sample     = sample_q;
  assign sample_vld = sample_vld_q;
  assign avg        = avg_q;
  assign avg_vld    = avg_vld_q;
  assign cal_done   = done_q;
  assign cal_fail   = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_latticesense_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_latticesense_ctrl
//  Description : Scoreboard bench for latticesense_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_latticesense_ctrl;

  logic        clk = 1'b0;
  logic        rstnin;
  logic        enain;
  logic        calin;
  logic [63:0] line_in;
  logic [63:0] line_drv;
  logic        cal_model;
  logic [4:0]  init_sel;
  logic [6:0]  sample;
  logic        sample_vld;
  logic [6:0]  avg;
  logic        avg_vld;
  logic        cal_busy;
  logic        cal_done;
  logic        cal_fail;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_avg = 0;
  bit chk_samp = 1'b1;

  int         exp_samp[$];
  logic [6:0] exp_avg[$];
  logic [4:0] exp_sel[$];

  always #5 clk = ~clk;

  // Wrapper model for calibration: ones = 112 - 4*init_sel, clamped.
  function automatic logic [63:0] model_line(input logic [4:0] sel);
    int o;
    logic [63:0] v;
    o = 112 - 4 * int'(sel);
    if (o < 0)  o = 0;
    if (o > 64) o = 64;
    v = '0;
    for (int i = 0; i < 64; i++) if (i < o) v[i] = 1'b1;
    return v;
  endfunction

  assign line_in = cal_model ? model_line(init_sel) : line_drv;

  latticesense_ctrl dut (
    .clkin      (clk),
    .rstnin     (rstnin),
    .enain      (enain),
    .calin      (calin),
    .line_in    (line_in),
    .init_sel   (init_sel),
    .sample     (sample),
    .sample_vld (sample_vld),
    .avg        (avg),
    .avg_vld    (avg_vld),
    .cal_busy   (cal_busy),
    .cal_done   (cal_done),
    .cal_fail   (cal_fail)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return sample_vld;
      1:       return avg_vld;
      default: return !cal_busy;
    endcase
  endfunction

  task automatic wait_for(input int which, input int bound, input string tag, output int t);
    int n;
    n = 0;
    while (!sig(which) && n < bound) begin
      tick(1);
      n++;
    end
    if (!sig(which)) chk(tag, 0, 1);
    t = cyc;
  endtask

  // Every enabled capture edge pushes the popcount the DUT must report two
  // edges later; a disabled edge or reset discards everything in flight.
  always @(posedge clk) begin
    cyc++;
    if (!rstnin || !enain) exp_samp.delete();
    else if (chk_samp)     exp_samp.push_back($countones(line_in));
  end

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (rstnin) begin
      if (sample_vld && chk_samp) begin
        if (exp_samp.size() == 0) chk("sample_unexpected", 1, 0);
        else                      chk("sample", sample, exp_samp.pop_front());
      end
      if (avg_vld) begin
        n_avg++;
        if (exp_avg.size() > 0) chk("avg", avg, exp_avg.pop_front());
        if (exp_sel.size() > 0) chk("init_sel_at_avg", init_sel, exp_sel.pop_front());
      end
    end
  end

  initial begin
    int c0, t1, t2, t3, nv, guard, nav0;
    rstnin    = 1'b0;
    enain     = 1'b0;
    calin     = 1'b0;
    cal_model = 1'b0;
    line_drv  = '0;
    tick(3);
    chk("rst_init_sel", init_sel, 13);
    chk("rst_sample", sample, 0);
    chk("rst_sample_vld", sample_vld, 0);
    chk("rst_avg", avg, 0);
    chk("rst_avg_vld", avg_vld, 0);
    chk("rst_busy", cal_busy, 0);
    chk("rst_done", cal_done, 0);
    chk("rst_fail", cal_fail, 0);
    rstnin = 1'b1;
    tick(2);

    // Half-full line: latency and window period.
    line_drv = 64'h0000_0000_FFFF_FFFF;
    exp_avg.push_back(7'd32);
    exp_avg.push_back(7'd32);
    enain = 1'b1;
    c0 = cyc;
    wait_for(0, 10, "timeout_first_svld", t1);
    chk("sample_latency", t1 - c0, 2);
    tick(1);
    wait_for(1, 40, "timeout_avg1", t2);
    chk("avg_latency", t2 - t1, 16);
    tick(1);
    wait_for(1, 40, "timeout_avg2", t3);
    chk("avg_period", t3 - t2, 16);

    // Bubbled line, then a partial window discarded by disabling.
    enain = 1'b0;
    tick(2);
    line_drv = 64'h0000_0000_0000_0F0F;
    enain = 1'b1;
    nv = 0;
    guard = 0;
    while (nv < 10 && guard < 40) begin
      tick(1);
      guard++;
      if (sample_vld) nv++;
    end
    chk("bubble_samples_seen", nv, 10);
    enain = 1'b0;
    nav0 = n_avg;
    tick(3);
    chk("hold_sample", sample, 8);
    chk("svld_off_when_disabled", sample_vld, 0);
    chk("no_partial_avg", n_avg, nav0);
    exp_avg.push_back(7'd8);
    enain = 1'b1;
    c0 = cyc;
    wait_for(1, 60, "timeout_restart_avg", t1);
    chk("restart_avg_latency", t1 - c0, 18);

    // Calibration converging 13 -> 16.
    chk_samp = 1'b0;
    enain = 1'b0;
    tick(2);
    exp_avg.delete();
    cal_model = 1'b1;
    enain = 1'b1;
    tick(3);
    calin = 1'b1;
    tick(1);
    calin = 1'b0;
    exp_avg.push_back(7'd60); exp_sel.push_back(5'd13);
    exp_avg.push_back(7'd56); exp_sel.push_back(5'd14);
    exp_avg.push_back(7'd52); exp_sel.push_back(5'd15);
    exp_avg.push_back(7'd48); exp_sel.push_back(5'd16);
    chk("cal_busy_started", cal_busy, 1);
    wait_for(2, 400, "timeout_cal", t1);
    chk("cal_done", cal_done, 1);
    chk("cal_fail_clear", cal_fail, 0);
    chk("cal_final_sel", init_sel, 16);
    chk("cal_avgs_consumed", exp_avg.size(), 0);

    // Saturation: all ones keeps pushing init_sel up to 31.
    cal_model = 1'b0;
    line_drv  = '1;
    tick(3);
    calin = 1'b1;
    tick(1);
    calin = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_avg.push_back(7'd64);
      exp_sel.push_back(5'(16 + i));
    end
    chk("sat_done_cleared", cal_done, 0);
    chk("sat_busy", cal_busy, 1);
    wait_for(2, 1500, "timeout_sat", t1);
    chk("sat_fail", cal_fail, 1);
    chk("sat_done", cal_done, 0);
    chk("sat_sel", init_sel, 31);
    chk("sat_avgs_consumed", exp_avg.size(), 0);
    exp_avg.delete();
    exp_sel.delete();

    // Abort during MEASURE; calin while busy is ignored.
    cal_model = 1'b1;
    calin = 1'b1;
    tick(1);
    calin = 1'b0;
    chk("abort_busy", cal_busy, 1);
    chk("abort_fail_cleared", cal_fail, 0);
    tick(8);
    calin = 1'b1;
    tick(1);
    calin = 1'b0;
    chk("calin_busy_ignored", cal_busy, 1);
    chk("abort_sel_pre", init_sel, 31);
    enain = 1'b0;
    tick(1);
    chk("abort_idle", cal_busy, 0);
    chk("abort_fail", cal_fail, 1);
    chk("abort_done", cal_done, 0);
    chk("abort_sel_kept", init_sel, 31);

    // Asynchronous reset in the middle of a calibration.
    cal_model = 1'b0;
    line_drv  = '1;
    enain = 1'b1;
    tick(1);
    wait_for(1, 40, "timeout_pre_rst_avg", t1);
    calin = 1'b1;
    tick(1);
    calin = 1'b0;
    tick(4);
    chk("pre_rst_busy", cal_busy, 1);
    chk("pre_rst_avg", avg, 64);
    #3;
    rstnin = 1'b0;
    #1;
    chk("arst_init_sel", init_sel, 13);
    chk("arst_busy", cal_busy, 0);
    chk("arst_sample", sample, 0);
    chk("arst_avg", avg, 0);
    chk("arst_sample_vld", sample_vld, 0);
    chk("arst_fail", cal_fail, 0);
    enain = 1'b0;
    tick(2);
    rstnin = 1'b1;
    tick(1);
    calin = 1'b1;
    tick(1);
    calin = 1'b0;
    chk("calin_disabled_ignored", cal_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
